// File: rtl/nervous_pkg.sv
// Purpose : shared level encoding and default window/threshold constants for the nerve-shock detector.
// Latency : n/a (types and constants only).
// Backpres: n/a.
package nervous_pkg;

  typedef enum logic [1:0] {
    NORMAL   = 2'b00,
    MILD     = 2'b01,
    SEVERE   = 2'b10,
    CRITICAL = 2'b11
  } nerve_level_t;

  localparam int WINDOW_DEF        = 16;
  localparam int MILD_THRESH_DEF   = 4;
  localparam int SEVERE_THRESH_DEF = 10;

  // Width that holds every value 0..win, used for the cycle and toggle counters.
  function automatic int cnt_width(input int win);
    return $clog2(win + 1);
  endfunction

endpackage

// File: rtl/nervous_toggle_window.sv
// Purpose : counts level toggles of a 1-bit sample stream over fixed, non-overlapping windows.
// Latency : win_done/win_toggles are combinational during the window's last sample cycle.
// Backpres: none; one sample is consumed every clock.
//
// Ports:
//   clock, reset  - rising-edge clock, async active-high reset
//   inputdata     - serial sample
//   win_done      - high for the one cycle whose edge closes the window
//   win_toggles   - toggle total for the window, including the closing sample
module nervous_toggle_window
  import nervous_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEF,
  parameter int CNT_W  = cnt_width(WINDOW)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inputdata,
  output logic             win_done,
  output logic [CNT_W-1:0] win_toggles
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  logic             prev_bit_q, prev_bit_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] tog_cnt_q, tog_cnt_d;
  logic             toggle;
  logic [CNT_W-1:0] tot;

  always_comb begin
    // The first sample after reset has no predecessor, so it never toggles.
    toggle      = ~first_q & (inputdata ^ prev_bit_q);
    tot         = tog_cnt_q + CNT_W'(toggle);
    win_done    = (cycle_cnt_q == LAST);
    win_toggles = tot;

    // prev_bit deliberately carries across window boundaries.
    prev_bit_d  = inputdata;
    first_d     = 1'b0;
    if (win_done) begin
      cycle_cnt_d = '0;
      tog_cnt_d   = '0;
    end else begin
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      tog_cnt_d   = tot;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_bit_q  <= 1'b0;
      first_q     <= 1'b1;
      cycle_cnt_q <= '0;
      tog_cnt_q   <= '0;
    end else begin
      prev_bit_q  <= prev_bit_d;
      first_q     <= first_d;
      cycle_cnt_q <= cycle_cnt_d;
      tog_cnt_q   <= tog_cnt_d;
    end
  end

endmodule

// File: rtl/nervous_shock_detector.sv
// Purpose : grades each toggle window of a serial nerve signal into NORMAL/MILD/SEVERE/CRITICAL.
// Latency : new level visible the cycle after the window's last sample edge; stable for a window.
// Backpres: none; free-running stream, one sample per clock.
//
// Ports:
//   clock, reset        - rising-edge clock, async active-high reset
//   inputdata           - serial nerve sample
//   nervousAbnormality  - registered level (00 NORMAL, 01 MILD, 10 SEVERE, 11 CRITICAL)
//
// Build option: define NERVOUS_LATCH_EN to make the output sticky at the highest level
// reached since reset; otherwise every window overwrites it.
module nervous_shock_detector
  import nervous_pkg::*;
#(
  parameter int WINDOW        = WINDOW_DEF,
  parameter int MILD_THRESH   = MILD_THRESH_DEF,
  parameter int SEVERE_THRESH = SEVERE_THRESH_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inputdata,
  output logic [1:0] nervousAbnormality
);

  localparam int               CNT_W  = cnt_width(WINDOW);
  localparam logic [CNT_W-1:0] MILD_T = CNT_W'(MILD_THRESH);
  localparam logic [CNT_W-1:0] SEV_T  = CNT_W'(SEVERE_THRESH);

  logic             win_done;
  logic [CNT_W-1:0] win_toggles;

  nerve_level_t lvl;
  nerve_level_t out_q, out_d;
  logic         sev_prev_q, sev_prev_d;
  logic         is_severe;

  nervous_toggle_window #(
    .WINDOW (WINDOW),
    .CNT_W  (CNT_W)
  ) u_window (
    .clock       (clock),
    .reset       (reset),
    .inputdata   (inputdata),
    .win_done    (win_done),
    .win_toggles (win_toggles)
  );

  always_comb begin
    is_severe = (win_toggles >= SEV_T);
    lvl       = NORMAL;
    if (is_severe) begin
      // Two severe windows back to back escalate to CRITICAL.
      lvl = sev_prev_q ? CRITICAL : SEVERE;
    end else if (win_toggles >= MILD_T) begin
      lvl = MILD;
    end

    sev_prev_d = sev_prev_q;
    out_d      = out_q;
    if (win_done) begin
      sev_prev_d = is_severe;
`ifdef NERVOUS_LATCH_EN
      if (lvl > out_q) begin
        out_d = lvl;
      end
`else
      out_d = lvl;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q      <= NORMAL;
      sev_prev_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      sev_prev_q <= sev_prev_d;
    end
  end

  assign nervousAbnormality = out_q;

endmodule

// File: tb/tb_nervous_shock_detector.sv
// Purpose : self-checking bench for nervous_shock_detector (WINDOW=8, MILD=3, SEVERE=6).
// Latency : expects each window's level one cycle after its last sample edge.
// Backpres: n/a; stimulus is a free-running sample stream.
module tb_nervous_shock_detector;

  localparam int W   = 8;
  localparam int MT  = 3;
  localparam int ST  = 6;

  logic       clock;
  logic       reset;
  logic       inputdata;
  logic [1:0] nervousAbnormality;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic       m_prev, m_first, m_sev;
  int         m_cyc, m_tog;
  logic [1:0] m_out;
  logic [1:0] exp_q[$];

  nervous_shock_detector #(
    .WINDOW        (W),
    .MILD_THRESH   (MT),
    .SEVERE_THRESH (ST)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .inputdata          (inputdata),
    .nervousAbnormality (nervousAbnormality)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev  = 1'b0;
    m_first = 1'b1;
    m_sev   = 1'b0;
    m_cyc   = 0;
    m_tog   = 0;
    m_out   = 2'b00;
    exp_q.delete();
  endtask

  // Drive one sample, advance the model to the same edge, then check after the edge.
  task automatic step(input logic b);
    logic       win_end;
    int         tot;
    logic [1:0] lvl;
    logic [1:0] e;
    inputdata = b;
    tot = m_tog + ((!m_first && (b != m_prev)) ? 1 : 0);
    m_prev  = b;
    m_first = 1'b0;
    win_end = (m_cyc == W - 1);
    if (win_end) begin
      if (tot >= ST)      lvl = m_sev ? 2'b11 : 2'b10;
      else if (tot >= MT) lvl = 2'b01;
      else                lvl = 2'b00;
      m_sev = (tot >= ST);
`ifdef NERVOUS_LATCH_EN
      if (lvl > m_out) m_out = lvl;
`else
      m_out = lvl;
`endif
      exp_q.push_back(m_out);
      m_cyc = 0;
      m_tog = 0;
    end else begin
      m_cyc++;
      m_tog = tot;
    end
    @(posedge clock);
    #1;
    if (win_end) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", nervousAbnormality, 2'bxx);
      end else begin
        e = exp_q.pop_front();
        chk("win_level", nervousAbnormality, e);
      end
    end else begin
      chk("hold", nervousAbnormality, m_out);
    end
  endtask

  // Async reset asserted between edges; output must clear before any edge.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_async", nervousAbnormality, 2'b00);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic alt(input int n);
    for (int i = 0; i < n; i++) step(~i[0]);
  endtask

  task automatic pat(input logic [7:0] bits);
    for (int i = 7; i >= 0; i--) step(bits[i]);
  endtask

  initial begin
    reset     = 1'b1;
    inputdata = 1'b0;
    model_reset();
    #1;
    chk("reset", nervousAbnormality, 2'b00);
    @(negedge clock);
    reset = 1'b0;

    // Constant zero: never abnormal.
    for (int i = 0; i < 32; i++) step(1'b0);
    chk("const0", nervousAbnormality, 2'b00);

    // Alternating: 7 toggles (first sample free) then 8.
    do_reset();
    alt(8);
    chk("alt_w1", nervousAbnormality, 2'b10);
    alt(8);
    chk("alt_w2", nervousAbnormality, 2'b11);
    for (int i = 0; i < 8; i++) step(1'b0);
`ifdef NERVOUS_LATCH_EN
    chk("after_quiet", nervousAbnormality, 2'b11);
`else
    chk("after_quiet", nervousAbnormality, 2'b00);
`endif

    // 1,1,0,0 repeating: 3 toggles, then 4 per window (boundary toggle counts).
    do_reset();
    for (int w = 0; w < 3; w++) begin
      pat(8'b1100_1100);
      chk("p1100", nervousAbnormality, 2'b01);
    end

    // Reset mid-window discards partial counts and the severe history.
    do_reset();
    alt(12);
    do_reset();
    alt(8);
    chk("post_rst", nervousAbnormality, 2'b10);

    // Threshold boundaries: exactly 6, 5, 2 toggles.
    do_reset();
    pat(8'b0101_0100);
    chk("exact6", nervousAbnormality, 2'b10);
    pat(8'b1010_1111);
`ifdef NERVOUS_LATCH_EN
    chk("exact5", nervousAbnormality, 2'b10);
`else
    chk("exact5", nervousAbnormality, 2'b01);
`endif
    pat(8'b0001_1111);
`ifdef NERVOUS_LATCH_EN
    chk("exact2", nervousAbnormality, 2'b10);
`else
    chk("exact2", nervousAbnormality, 2'b00);
`endif

    // Randomised tail against the model.
    do_reset();
    for (int i = 0; i < 160; i++) step(1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
